// File: rtl/hand_tracker_pkg.sv
// Shared definitions for the hand tracker: screen geometry, FSM encoding and
// the saturating velocity helper.
package hand_tracker_pkg;

    localparam int unsigned MAX_Y = 309;
    localparam int unsigned ROW_W = 9;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_UPDATE    = 3'd4,
        S_TIMEOUT   = 3'd5
    } state_t;

    // Negative or zero delta (upward or no motion) reports zero speed.
    function automatic logic [7:0] sat_vel(input logic [9:0] delta, input int unsigned shift);
        logic [31:0] wide;
        if (delta[9] || (delta == 10'd0)) begin
            return 8'd0;
        end
        wide = 32'(delta) << shift;
        return (wide > 32'd255) ? 8'hFF : wide[7:0];
    endfunction

endpackage

// File: rtl/hand_tracker_echo_sync.sv
// Two-flop synchronizer for the sensor echo pin with one-cycle rise/fall
// strobes derived from the synchronized level.
module hand_tracker_echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo,
    output logic echo_rise,
    output logic echo_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = echo;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign echo_rise = sync_q & ~prev_q;
    assign echo_fall = ~sync_q & prev_q;

endmodule

// File: rtl/hand_tracker.sv
// Ultrasonic hand-position front end: periodic trigger, echo timing, row
// quantisation and downward-speed estimate for the ball physics block.
module hand_tracker
    import hand_tracker_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = 120,
    parameter int unsigned PERIOD_CYCLES  = 720000,
    parameter int unsigned TIMEOUT_CYCLES = 360000,
    parameter int unsigned CYC_PER_ROW    = 70,
    parameter int unsigned VEL_SHIFT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             echo,
    output logic             trig,
    output logic [ROW_W-1:0] handline,
    output logic [7:0]       hand_velocity,
    output logic             sample_valid,
    output logic             no_hand,
    output state_t           state_dbg
);

    localparam int unsigned PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TR_W  = $clog2(TRIG_CYCLES + 1);
    localparam int unsigned PS_W  = $clog2(CYC_PER_ROW + 1);

    // Handshake-free block: sample_valid is a one-cycle strobe; handline,
    // hand_velocity and no_hand are stable whenever sample_valid is low.

    logic echo_rise, echo_fall;

    hand_tracker_echo_sync u_echo_sync (
        .clk       (clk),
        .rst       (rst),
        .echo      (echo),
        .echo_rise (echo_rise),
        .echo_fall (echo_fall)
    );

    state_t           state_q, state_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [TR_W-1:0]  trig_cnt_q, trig_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [PS_W-1:0]  ps_cnt_q, ps_cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] handline_q, handline_d;
    logic [7:0]       vel_q, vel_d;
    logic             sv_q, sv_d;
    logic             no_hand_q, no_hand_d;
    logic             prev_valid_q, prev_valid_d;
    logic             trig_q, trig_d;

    logic             tick;
    logic             to_hit;
    logic [9:0]       delta;

    assign tick   = (per_cnt_q == PER_W'(PERIOD_CYCLES - 1));
    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign delta  = {1'b0, row_q} - {1'b0, handline_q};

    always_comb begin
        state_d      = state_q;
        per_cnt_d    = tick ? '0 : per_cnt_q + 1'b1;
        trig_cnt_d   = '0;
        to_cnt_d     = '0;
        ps_cnt_d     = '0;
        row_d        = '0;
        handline_d   = handline_q;
        vel_d        = vel_q;
        sv_d         = 1'b0;
        no_hand_d    = no_hand_q;
        prev_valid_d = prev_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_TRIG;
            end
            S_TRIG: begin
                if (trig_cnt_q == TR_W'(TRIG_CYCLES - 1)) begin
                    state_d = S_WAIT_RISE;
                end else begin
                    trig_cnt_d = trig_cnt_q + 1'b1;
                end
            end
            S_WAIT_RISE: begin
                // Only a fresh rising edge counts, so an echo stuck high times out.
                to_cnt_d = to_cnt_q + 1'b1;
                if (to_hit) begin
                    state_d = S_TIMEOUT;
                end else if (echo_rise) begin
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                to_cnt_d = to_cnt_q + 1'b1;
                row_d    = row_q;
                if (ps_cnt_q == PS_W'(CYC_PER_ROW - 1)) begin
                    if (row_q != ROW_W'(MAX_Y)) row_d = row_q + 1'b1;
                end else begin
                    ps_cnt_d = ps_cnt_q + 1'b1;
                end
                if (to_hit) begin
                    state_d = S_TIMEOUT;
                end else if (echo_fall) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                handline_d   = row_q;
                vel_d        = prev_valid_q ? sat_vel(delta, VEL_SHIFT) : 8'd0;
                sv_d         = 1'b1;
                no_hand_d    = 1'b0;
                prev_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_TIMEOUT: begin
                handline_d   = '0;
                vel_d        = 8'd0;
                sv_d         = 1'b1;
                no_hand_d    = 1'b1;
                prev_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered so the pin is glitch-free yet still drops with async reset.
    assign trig_d = (state_d == S_TRIG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            per_cnt_q    <= '0;
            trig_cnt_q   <= '0;
            to_cnt_q     <= '0;
            ps_cnt_q     <= '0;
            row_q        <= '0;
            handline_q   <= '0;
            vel_q        <= 8'd0;
            sv_q         <= 1'b0;
            no_hand_q    <= 1'b1;
            prev_valid_q <= 1'b0;
            trig_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            trig_cnt_q   <= trig_cnt_d;
            to_cnt_q     <= to_cnt_d;
            ps_cnt_q     <= ps_cnt_d;
            row_q        <= row_d;
            handline_q   <= handline_d;
            vel_q        <= vel_d;
            sv_q         <= sv_d;
            no_hand_q    <= no_hand_d;
            prev_valid_q <= prev_valid_d;
            trig_q       <= trig_d;
        end
    end

    assign trig          = trig_q;
    assign handline      = handline_q;
    assign hand_velocity = vel_q;
    assign sample_valid  = sv_q;
    assign no_hand       = no_hand_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_hand_tracker.sv
// Directed plus randomized bench for hand_tracker; two instances differ only
// in VEL_SHIFT so both the plain and shifted velocity paths are exercised.
module tb_hand_tracker;
    import hand_tracker_pkg::*;

    localparam int TRIG  = 3;
    localparam int PER   = 2000;
    localparam int TO    = 1500;
    localparam int CPR   = 4;
    localparam int Y_BOT = 309;

    logic clk = 1'b0;
    logic rst;
    logic echo;

    logic       trig0, trig1, sv0, sv1, nh0, nh1;
    logic [8:0] hl0, hl1;
    logic [7:0] v0, v1;
    state_t     st0, st1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] exp_q0[$];
    logic [17:0] exp_q1[$];
    int m_hl[2];
    bit m_prev[2];
    int shifts[2] = '{0, 2};

    always #5 clk = ~clk;

    hand_tracker #(.TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TO),
                   .CYC_PER_ROW(CPR), .VEL_SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .echo(echo), .trig(trig0), .handline(hl0),
        .hand_velocity(v0), .sample_valid(sv0), .no_hand(nh0), .state_dbg(st0)
    );

    hand_tracker #(.TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TO),
                   .CYC_PER_ROW(CPR), .VEL_SHIFT(2)) u_dut1 (
        .clk(clk), .rst(rst), .echo(echo), .trig(trig1), .handline(hl1),
        .hand_velocity(v1), .sample_valid(sv1), .no_hand(nh1), .state_dbg(st1)
    );

    initial begin
        #1_500_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hl[k]   = 0;
            m_prev[k] = 1'b0;
        end
    endfunction

    // Reference: row = floor(width/CPR) capped at the bottom row; speed is the
    // positive row increase since the last good sample, shifted and capped.
    function automatic void model_meas(input int width, input bit timed_out);
        for (int k = 0; k < 2; k++) begin
            int row;
            int vel;
            logic [17:0] e;
            if (timed_out) begin
                m_hl[k]   = 0;
                m_prev[k] = 1'b0;
                e = {9'd0, 8'd0, 1'b1};
            end else begin
                row = width / CPR;
                if (row > Y_BOT) row = Y_BOT;
                vel = 0;
                if (m_prev[k] && row > m_hl[k]) begin
                    vel = (row - m_hl[k]) << shifts[k];
                    if (vel > 255) vel = 255;
                end
                m_hl[k]   = row;
                m_prev[k] = 1'b1;
                e = {9'(row), 8'(vel), 1'b0};
            end
            if (k == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
    endfunction

    task automatic wait_trig_rise();
        int n = 0;
        while (trig0 !== 1'b1 && n < 2500) begin
            @(negedge clk);
            n++;
        end
        check("trig_rise_seen", 32'(trig0), 32'd1);
    endtask

    task automatic count_trig();
        int n = 0;
        while (trig0 === 1'b1 && n < 10) begin
            check("trig_pair", 32'(trig1), 32'(trig0));
            @(negedge clk);
            n++;
        end
        check("trig_width", 32'(n), 32'(TRIG));
    endtask

    task automatic wait_strobe_check(input string tag);
        int n = 0;
        logic [17:0] e0, e1;
        while (sv0 !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_strobe"}, 32'(sv0), 32'd1);
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        check({tag, "_hl"},     32'(hl0), 32'(e0[17:9]));
        check({tag, "_vel"},    32'(v0),  32'(e0[8:1]));
        check({tag, "_nohand"}, 32'(nh0), 32'(e0[0]));
        check({tag, "_sv_s2"},  32'(sv1), 32'd1);
        check({tag, "_hl_s2"},  32'(hl1), 32'(e1[17:9]));
        check({tag, "_vel_s2"}, 32'(v1),  32'(e1[8:1]));
        @(negedge clk);
        check({tag, "_one_strobe"}, 32'(sv0), 32'd0);
    endtask

    task automatic drive_pulse(input int delay, input int width);
        repeat (delay) @(negedge clk);
        echo = 1'b1;
        repeat (width) @(negedge clk);
        echo = 1'b0;
    endtask

    task automatic do_meas(input string tag, input int delay, input int width);
        wait_trig_rise();
        count_trig();
        model_meas(width, (delay + width) >= TO);
        fork
            drive_pulse(delay, width);
            wait_strobe_check(tag);
        join
    endtask

    initial begin
        int mcnt;
        int n;
        rst  = 1'b0;
        echo = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_trig",   32'(trig0), 32'd0);
        check("rst_hl",     32'(hl0),   32'd0);
        check("rst_vel",    32'(v0),    32'd0);
        check("rst_sv",     32'(sv0),   32'd0);
        check("rst_nohand", 32'(nh0),   32'd1);
        check("rst_state",  32'(st0),   32'(S_IDLE));
        rst = 1'b1;

        do_meas("t1_first", 10, 400);
        do_meas("t2_down", 7, 480);
        do_meas("t2_up", 12, 400);

        // Echo outlasts the timeout window and still covers the next trigger.
        do_meas("t3_timeout", 1, 2000);
        model_meas(0, 1'b1);
        wait_strobe_check("t3_overlap");
        do_meas("t3_noprev", 9, 400);

        do_meas("t4_step", 5, 800);
        do_meas("t4_sat", 5, 1300);

        echo = 1'b1;
        wait_trig_rise();
        count_trig();
        model_meas(0, 1'b1);
        mcnt = 0;
        n = 0;
        while (sv0 !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
            if (st0 == S_MEASURE) mcnt++;
        end
        wait_strobe_check("t5_stuck");
        check("t5_no_measure", 32'(mcnt), 32'd0);
        echo = 1'b0;

        wait_trig_rise();
        echo = 1'b1;
        @(negedge clk);
        echo = 1'b0;
        model_meas(0, 1'b1);
        wait_strobe_check("t5_trig_pulse");

        for (int i = 0; i < 5; i++) begin
            int d;
            int w;
            d = $urandom_range(1, 40);
            w = $urandom_range(4, 1400);
            do_meas($sformatf("rnd%0d", i), d, w);
        end

        wait_trig_rise();
        count_trig();
        repeat (5) @(negedge clk);
        echo = 1'b1;
        repeat (100) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check("t6_trig",   32'(trig0), 32'd0);
        check("t6_hl",     32'(hl0),   32'd0);
        check("t6_vel",    32'(v0),    32'd0);
        check("t6_nohand", 32'(nh0),   32'd1);
        check("t6_state",  32'(st0),   32'(S_IDLE));
        check("t6_hl_s2",  32'(hl1),   32'd0);
        model_reset();
        echo = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        wait_trig_rise();
        #3 rst = 1'b0;
        #1;
        check("t6_trig_drop",    32'(trig0), 32'd0);
        check("t6_trig_drop_s2", 32'(trig1), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        do_meas("t6_clean", 10, 400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
